// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - opcodes, status codes and FSM states for the byte-stream APB initiator
package apb_master_pkg;

  localparam logic [7:0] OP_WRITE   = 8'h57;
  localparam logic [7:0] OP_READ    = 8'h52;

  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_SLVERR  = 8'h01;
  localparam logic [7:0] ST_TIMEOUT = 8'h02;
  localparam logic [7:0] ST_BADOP   = 8'hEE;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ADDR      = 3'd1;
  localparam logic [2:0] S_WDATA     = 3'd2;
  localparam logic [2:0] S_SETUP     = 3'd3;
  localparam logic [2:0] S_ACCESS    = 3'd4;
  localparam logic [2:0] S_RESP_STAT = 3'd5;
  localparam logic [2:0] S_RESP_DATA = 3'd6;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_apb_master.sv
// rtl/axis_apb_master.sv - executes one APB read/write per command frame received as 8-bit stream bytes
module axis_apb_master
  import apb_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 1024
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [7:0]                s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [7:0]                m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [APB_ADDR_WIDTH-1:0] m_apb_paddr,
  output logic [APB_DATA_WIDTH-1:0] m_apb_pwdata,
  output logic                      m_apb_pwrite,
  output logic                      m_apb_psel,
  output logic                      m_apb_penable,
  input  logic [APB_DATA_WIDTH-1:0] m_apb_prdata,
  input  logic                      m_apb_pready,
  input  logic                      m_apb_pslverr
);

  localparam int AB = APB_ADDR_WIDTH / 8;
  localparam int DB = APB_DATA_WIDTH / 8;
  localparam int CW = $clog2(max_int(AB, DB) + 1);
  localparam int TW = $clog2(TIMEOUT);

  logic [2:0]                state;
  logic [CW-1:0]             cnt;
  logic [TW-1:0]             tcnt;
  logic [7:0]                status;
  logic [APB_DATA_WIDTH-1:0] rdata;
  logic                      run;
  logic                      s_hs;
  logic                      m_hs;

  // run keeps tready low until the first clock after reset release
  assign s_axis_tready = run && (state == S_IDLE || state == S_ADDR || state == S_WDATA);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign m_axis_tvalid = (state == S_RESP_STAT) || (state == S_RESP_DATA);
  assign m_hs          = m_axis_tvalid && m_axis_tready;
  assign m_apb_psel    = (state == S_SETUP) || (state == S_ACCESS);
  assign m_apb_penable = (state == S_ACCESS);

  always_comb begin
    m_axis_tdata = 8'h00;
    if (state == S_RESP_STAT)      m_axis_tdata = status;
    else if (state == S_RESP_DATA) m_axis_tdata = rdata[7:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state        <= S_IDLE;
      cnt          <= '0;
      tcnt         <= '0;
      status       <= ST_OK;
      rdata        <= '0;
      run          <= 1'b0;
      m_apb_paddr  <= '0;
      m_apb_pwdata <= '0;
      m_apb_pwrite <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        S_IDLE: if (s_hs) begin
          cnt <= '0;
          if (s_axis_tdata == OP_WRITE || s_axis_tdata == OP_READ) begin
            m_apb_pwrite <= (s_axis_tdata == OP_WRITE);
            state        <= S_ADDR;
          end else begin
            status <= ST_BADOP;
            state  <= S_RESP_STAT;
          end
        end
        // little-endian: each new byte enters at the top and drifts down
        S_ADDR: if (s_hs) begin
          m_apb_paddr <= (m_apb_paddr >> 8) |
                         (APB_ADDR_WIDTH'(s_axis_tdata) << (APB_ADDR_WIDTH - 8));
          if (cnt == CW'(AB - 1)) begin
            cnt   <= '0;
            state <= m_apb_pwrite ? S_WDATA : S_SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WDATA: if (s_hs) begin
          m_apb_pwdata <= (m_apb_pwdata >> 8) |
                          (APB_DATA_WIDTH'(s_axis_tdata) << (APB_DATA_WIDTH - 8));
          if (cnt == CW'(DB - 1)) begin
            cnt   <= '0;
            state <= S_SETUP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SETUP: begin
          tcnt  <= '0;
          state <= S_ACCESS;
        end
        S_ACCESS: begin
          if (m_apb_pready) begin
            status <= m_apb_pslverr ? ST_SLVERR : ST_OK;
            rdata  <= m_apb_prdata;
            state  <= S_RESP_STAT;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            status <= ST_TIMEOUT;
            state  <= S_RESP_STAT;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        // pwrite is stale after a bad opcode, but status then excludes the data phase
        S_RESP_STAT: if (m_hs) begin
          cnt   <= '0;
          state <= (!m_apb_pwrite && (status == ST_OK || status == ST_SLVERR))
                   ? S_RESP_DATA : S_IDLE;
        end
        S_RESP_DATA: if (m_hs) begin
          rdata <= rdata >> 8;
          if (cnt == CW'(DB - 1)) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_apb_master.sv
// tb/tb_axis_apb_master.sv - directed self-checking bench for axis_apb_master
module tb_axis_apb_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready = 1'b1;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] prdata = 32'h0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int checks = 0;
  int failures = 0;

  axis_apb_master #(
    .APB_ADDR_WIDTH(32),
    .APB_DATA_WIDTH(32),
    .TIMEOUT(TO)
  ) dut (
    .clk_i(clk),
    .rstn_i(rstn),
    .s_axis_tdata(s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_apb_paddr(paddr),
    .m_apb_pwdata(pwdata),
    .m_apb_pwrite(pwrite),
    .m_apb_psel(psel),
    .m_apb_penable(penable),
    .m_apb_prdata(prdata),
    .m_apb_pready(pready),
    .m_apb_pslverr(pslverr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // called at a negedge; returns at the negedge after the handshake edge
  task automatic send_byte(input logic [7:0] b);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = b;
    n = 0;
    while (!s_tready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("s_tready", {31'b0, s_tready}, 32'd1);
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] op, input logic [31:0] a);
    send_byte(op);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
  endtask

  task automatic send_data(input logic [31:0] d);
    for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
  endtask

  // entered at the SETUP negedge; pslverr is held high during waits to show it is ignored
  task automatic serve(input logic exp_w, input logic [31:0] exp_a, input logic [31:0] exp_d,
                       input int waits, input logic err, input logic [31:0] rd, input bit never);
    chk("setup_psel", {31'b0, psel}, 32'd1);
    chk("setup_penable", {31'b0, penable}, 32'd0);
    chk("setup_pwrite", {31'b0, pwrite}, {31'b0, exp_w});
    chk("setup_paddr", paddr, exp_a);
    if (exp_w) chk("setup_pwdata", pwdata, exp_d);
    @(negedge clk);
    if (never) begin
      for (int k = 0; k < TO; k++) begin
        chk("to_psel", {31'b0, psel}, 32'd1);
        chk("to_penable", {31'b0, penable}, 32'd1);
        @(negedge clk);
      end
      chk("to_psel_drop", {31'b0, psel}, 32'd0);
      chk("to_penable_drop", {31'b0, penable}, 32'd0);
    end else begin
      for (int k = 0; k < waits; k++) begin
        pslverr = 1'b1;
        chk("wait_penable", {31'b0, penable}, 32'd1);
        @(negedge clk);
      end
      pready  = 1'b1;
      pslverr = err;
      prdata  = rd;
      chk("access_penable", {31'b0, penable}, 32'd1);
      chk("access_paddr", paddr, exp_a);
      chk("access_pwrite", {31'b0, pwrite}, {31'b0, exp_w});
      @(negedge clk);
      pready  = 1'b0;
      pslverr = 1'b0;
      prdata  = 32'h0;
      chk("post_psel", {31'b0, psel}, 32'd0);
    end
  endtask

  task automatic recv(input string tag, input logic [7:0] exp);
    int n;
    n = 0;
    while (!m_tvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_tvalid"}, {31'b0, m_tvalid}, 32'd1);
    chk(tag, {24'b0, m_tdata}, {24'b0, exp});
    @(negedge clk);
  endtask

  task automatic recv_data(input string tag, input logic [31:0] d);
    for (int i = 0; i < 4; i++) recv(tag, d[8*i +: 8]);
    chk({tag, "_end"}, {31'b0, m_tvalid}, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("rst_psel", {31'b0, psel}, 32'd0);
    chk("rst_penable", {31'b0, penable}, 32'd0);
    chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_s_tready", {31'b0, s_tready}, 32'd0);
    chk("rst_m_tvalid", {31'b0, m_tvalid}, 32'd0);
    chk("rst_m_tdata", {24'b0, m_tdata}, 32'd0);
    rstn = 1'b1;
    chk("rel_s_tready", {31'b0, s_tready}, 32'd0);
    @(negedge clk);
    chk("rel1_s_tready", {31'b0, s_tready}, 32'd1);

    // minimal write: status is valid right after the single ACCESS cycle
    send_hdr(8'h57, 32'h0000_0010);
    send_data(32'hDEAD_BEEF);
    serve(1'b1, 32'h10, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, 1'b0);
    chk("wr_immediate_tvalid", {31'b0, m_tvalid}, 32'd1);
    recv("wr_status", 8'h00);
    chk("wr_end", {31'b0, m_tvalid}, 32'd0);

    // read with 3 wait states, status back-pressured for 5 cycles
    m_tready = 1'b0;
    send_hdr(8'h52, 32'h0000_0004);
    serve(1'b0, 32'h4, 32'h0, 3, 1'b0, 32'h1234_5678, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_tvalid", {31'b0, m_tvalid}, 32'd1);
      chk("bp_tdata", {24'b0, m_tdata}, 32'h00);
      @(negedge clk);
    end
    m_tready = 1'b1;
    recv("rd_status", 8'h00);
    recv_data("rd_data", 32'h1234_5678);

    // write with slave error
    send_hdr(8'h57, 32'h0000_0020);
    send_data(32'h1122_3344);
    serve(1'b1, 32'h20, 32'h1122_3344, 1, 1'b1, 32'h0, 1'b0);
    recv("wr_err_status", 8'h01);
    chk("wr_err_end", {31'b0, m_tvalid}, 32'd0);

    // read with slave error still returns data
    send_hdr(8'h52, 32'h0000_0008);
    serve(1'b0, 32'h8, 32'h0, 2, 1'b1, 32'hCAFE_F00D, 1'b0);
    recv("rd_err_status", 8'h01);
    recv_data("rd_err_data", 32'hCAFE_F00D);

    // timeout, then a late pready must be ignored
    send_hdr(8'h52, 32'h0000_0030);
    serve(1'b0, 32'h30, 32'h0, 0, 1'b0, 32'h0, 1'b1);
    pready = 1'b1;
    recv("to_status", 8'h02);
    chk("to_late_psel", {31'b0, psel}, 32'd0);
    pready = 1'b0;
    chk("to_end", {31'b0, m_tvalid}, 32'd0);

    send_hdr(8'h57, 32'h0000_0040);
    send_data(32'h0403_0201);
    serve(1'b1, 32'h40, 32'h0403_0201, 0, 1'b0, 32'h0, 1'b0);
    recv("after_to_status", 8'h00);

    // bad opcode: no APB activity, then a normal read
    send_byte(8'h41);
    chk("badop_psel", {31'b0, psel}, 32'd0);
    recv("badop_status", 8'hEE);
    chk("badop_end", {31'b0, m_tvalid}, 32'd0);
    send_hdr(8'h52, 32'h0000_000C);
    serve(1'b0, 32'hC, 32'h0, 0, 1'b0, 32'hA5A5_5A5A, 1'b0);
    recv("after_bad_status", 8'h00);
    recv_data("after_bad_data", 32'hA5A5_5A5A);

    // reset during ACCESS
    send_hdr(8'h57, 32'h0000_0050);
    send_data(32'h5555_AAAA);
    chk("rr_setup_psel", {31'b0, psel}, 32'd1);
    @(negedge clk);
    chk("rr_access_penable", {31'b0, penable}, 32'd1);
    #1 rstn = 1'b0;
    #1;
    chk("rr_psel", {31'b0, psel}, 32'd0);
    chk("rr_penable", {31'b0, penable}, 32'd0);
    chk("rr_paddr", paddr, 32'd0);
    chk("rr_pwdata", pwdata, 32'd0);
    chk("rr_pwrite", {31'b0, pwrite}, 32'd0);
    chk("rr_s_tready", {31'b0, s_tready}, 32'd0);
    chk("rr_m_tvalid", {31'b0, m_tvalid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    chk("rr_rel_s_tready", {31'b0, s_tready}, 32'd0);
    @(negedge clk);
    chk("rr_rel1_s_tready", {31'b0, s_tready}, 32'd1);
    send_hdr(8'h52, 32'h0000_0060);
    serve(1'b0, 32'h60, 32'h0, 1, 1'b0, 32'h8765_4321, 1'b0);
    recv("rr_rd_status", 8'h00);
    recv_data("rr_rd_data", 32'h8765_4321);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
